// File: rtl/uart_pkg.sv
// uart_pkg
// Shared constants and types for the UART transmit path.
//   c_CLKS_PER_BIT : baud divider for a 10 ns clock at 460800 baud
//   c_BYTE_W       : width of one serial data byte
//   tx_state_e     : launch controller states in front of uart_tx
package uart_pkg;

    localparam int c_CLKS_PER_BIT = 217;
    localparam int c_BYTE_W       = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo_8.sv
// sync_fifo_8
// Circular byte FIFO with a separate occupancy counter.
// Ports:
//   clk, rst   : clock and asynchronous active-high reset
//   push       : enqueue request, with push_data
//   pop        : dequeue the head; the caller only pops when not empty
//   head_data  : current head entry, valid while not empty
//   full/empty : decoded from the occupancy count
//   count      : occupancy, 0..DEPTH
//   overflow   : one-cycle pulse the cycle after a push was dropped
module sync_fifo_8
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [c_BYTE_W-1:0] push_data,
    input  logic                pop,
    output logic [c_BYTE_W-1:0] head_data,
    output logic                full,
    output logic                empty,
    output logic [ADDR_W:0]     count,
    output logic                overflow
);

    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

    logic [c_BYTE_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                accept;

    // A push is still accepted when full if the head leaves in the same
    // cycle, because the freed slot is exactly the one being written.
    always_comb begin
        accept     = push && ((count_q != DEPTH_C) || pop);
        overflow_d = push && !accept;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (accept && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !accept) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage has no reset; stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign overflow  = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte buffer and launch controller placed in front of uart_tx.
// Ports:
//   i_Clock, i_Reset      : clock and asynchronous active-high reset
//   i_Wr_DV, i_Wr_Byte    : host write strobe and byte
//   o_Full, o_Empty       : FIFO occupancy flags
//   o_Count               : FIFO occupancy, 0..DEPTH
//   o_Overflow            : one-cycle pulse after a dropped write
//   i_TX_Active, i_TX_Done: status from uart_tx
//   o_TX_DV, o_TX_Byte    : launch handshake to uart_tx
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
)
(
    input  logic                i_Clock,
    input  logic                i_Reset,
    input  logic                i_Wr_DV,
    input  logic [c_BYTE_W-1:0] i_Wr_Byte,
    output logic                o_Full,
    output logic                o_Empty,
    output logic [ADDR_W:0]     o_Count,
    output logic                o_Overflow,
    input  logic                i_TX_Active,
    input  logic                i_TX_Done,
    output logic                o_TX_DV,
    output logic [c_BYTE_W-1:0] o_TX_Byte
);

    tx_state_e           state_q, state_d;
    logic                tx_dv_q, tx_dv_d;
    logic [c_BYTE_W-1:0] tx_byte_q, tx_byte_d;
    logic                pop;
    logic [c_BYTE_W-1:0] head_data;
    logic                fifo_empty;

    sync_fifo_8 #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (i_Clock),
        .rst       (i_Reset),
        .push      (i_Wr_DV),
        .push_data (i_Wr_Byte),
        .pop       (pop),
        .head_data (head_data),
        .full      (o_Full),
        .empty     (fifo_empty),
        .count     (o_Count),
        .overflow  (o_Overflow)
    );

    // Launch only when uart_tx reports idle: after a reset of this block
    // uart_tx may still be finishing a frame it was given earlier.
    // GAP absorbs the cycle uart_tx spends cleaning up after o_TX_Done.
    always_comb begin
        state_d   = state_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !i_TX_Active) begin
                    pop       = 1'b1;
                    tx_byte_d = head_data;
                    tx_dv_d   = 1'b1;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_TX_Done) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= IDLE;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    assign o_Empty   = fifo_empty;
    assign o_TX_DV   = tx_dv_q;
    assign o_TX_Byte = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Self-checking bench for uart_tx_fifo. A behavioural uart_tx stand-in
// answers launches with a frame of random length; a queue-based reference
// model predicts occupancy, drops and launch cycles; a scoreboard matches
// every launched byte against the expected transmit order.
module tb_uart_tx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              wr_dv;
    logic [7:0]        wr_byte;
    logic              o_full, o_empty, o_overflow, o_tx_dv;
    logic [ADDR_W:0]   o_count;
    logic [7:0]        o_tx_byte;
    logic              stub_active, hold_active, tx_done;
    logic              tx_active;

    assign tx_active = stub_active | hold_active;

    always #5 clock = ~clock;

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_Clock     (clock),
        .i_Reset     (reset),
        .i_Wr_DV     (wr_dv),
        .i_Wr_Byte   (wr_byte),
        .o_Full      (o_full),
        .o_Empty     (o_empty),
        .o_Count     (o_count),
        .o_Overflow  (o_overflow),
        .i_TX_Active (tx_active),
        .i_TX_Done   (tx_done),
        .o_TX_DV     (o_tx_dv),
        .o_TX_Byte   (o_tx_byte)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model state: FIFO contents, launcher availability, and
    // the per-cycle predictions for the launch pulse and the drop pulse.
    logic [7:0] m_q [$];
    logic [7:0] sb [$];
    int  cyc      = 0;
    int  free_at  = 0;
    int  launch_c = 0;
    bit  in_frame = 0;
    bit  exp_dv   = 0;
    bit  exp_ovf  = 0;

    // Launch rule: the launcher may fire when it is not waiting on a frame,
    // at least two cycles after the last accepted done, with data queued
    // and the line idle. Done counts only once the launch pulse is over.
    initial begin
        bit launch, accept;
        forever begin
            @(posedge clock);
            if (reset) begin
                m_q.delete();
                sb.delete();
                in_frame = 0;
                free_at  = 0;
                exp_dv   = 0;
                exp_ovf  = 0;
            end else begin
                launch = !in_frame && (cyc >= free_at) && (m_q.size() > 0) && !tx_active;
                if (in_frame && tx_done && (cyc >= launch_c + 2)) begin
                    in_frame = 0;
                    free_at  = cyc + 2;
                end
                accept  = wr_dv && ((m_q.size() < DEPTH) || launch);
                exp_dv  = launch;
                exp_ovf = wr_dv && !accept;
                if (launch) begin
                    sb.push_back(m_q.pop_front());
                    in_frame = 1;
                    launch_c = cyc;
                end
                if (accept) begin
                    m_q.push_back(wr_byte);
                end
            end
            cyc++;
        end
    end

    // Cycle-by-cycle comparison against the model plus protocol invariants.
    int peak    = 0;
    bit prev_dv = 0;
    initial begin
        forever begin
            @(posedge clock);
            #3;
            if (!reset) begin
                check("tx_dv", o_tx_dv, exp_dv);
                check("overflow", o_overflow, exp_ovf);
                check("count", o_count, m_q.size());
                check("empty", o_empty, int'(m_q.size() == 0));
                check("full", o_full, int'(m_q.size() == DEPTH));
                check("dv_while_active", int'(o_tx_dv && tx_active), 0);
                check("dv_single_cycle", int'(o_tx_dv && prev_dv), 0);
                if (o_count > peak) peak = o_count;
                prev_dv = o_tx_dv;
            end else begin
                prev_dv = 0;
            end
        end
    end

    // Scoreboard monitor: every launch must carry the next expected byte.
    int         dv_count = 0;
    logic [7:0] last_tx  = 8'h00;
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(posedge clock);
            #3;
            if (!reset && o_tx_dv) begin
                dv_count++;
                check("sb_pending", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    exp_b = sb.pop_front();
                    check("tx_byte", o_tx_byte, exp_b);
                end
                last_tx = o_tx_byte;
            end
        end
    end

    // uart_tx stand-in: busy for a random number of cycles per frame, done
    // pulses with active falling. It is not reset by this block's reset.
    bit         stub_busy   = 0;
    bit         stale       = 0;
    bit         spurious_en = 0;
    int         remaining   = 0;
    logic [7:0] held        = 8'h00;
    initial begin
        stub_active = 1'b0;
        tx_done     = 1'b0;
        forever begin
            @(negedge clock);
            #1;
            if (reset) stale = 1;
            tx_done = 1'b0;
            if (stub_busy) begin
                if (!stale) check("byte_hold", o_tx_byte, held);
                remaining--;
                if (remaining == 0) begin
                    stub_busy   = 0;
                    stub_active = 1'b0;
                    tx_done     = 1'b1;
                end
            end else if (o_tx_dv) begin
                stub_busy   = 1;
                stub_active = 1'b1;
                held        = o_tx_byte;
                stale       = 0;
                remaining   = $urandom_range(2, 12);
            end else if (spurious_en && ($urandom_range(0, 15) == 0)) begin
                tx_done = 1'b1;
            end
        end
    end

    task automatic drive(input logic dv, input logic [7:0] b);
        @(negedge clock);
        wr_dv   = dv;
        wr_byte = b;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((m_q.size() != 0 || in_frame || sb.size() != 0 || stub_busy || tx_done) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check({name, "_drained"}, int'(n < 3000), 1);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base, n;
        reset       = 1'b1;
        wr_dv       = 1'b0;
        wr_byte     = 8'h00;
        hold_active = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_count", o_count, 0);
        check("rst_empty", o_empty, 1);
        check("rst_full", o_full, 0);
        check("rst_overflow", o_overflow, 0);
        check("rst_tx_dv", o_tx_dv, 0);
        check("rst_tx_byte", o_tx_byte, 0);
        reset = 1'b0;

        // Single byte: launch two cycles after the write cycle.
        $display("[TB] single byte");
        drive(1'b1, 8'h3F);
        @(posedge clock); #3;
        check("single_no_early_dv", o_tx_dv, 0);
        check("single_count", o_count, 1);
        drive(1'b0, 8'h00);
        @(posedge clock); #3;
        check("single_dv", o_tx_dv, 1);
        check("single_byte", o_tx_byte, 8'h3F);
        wait_drain("single");
        check("single_empty_after", o_empty, 1);

        // Burst of five consecutive writes.
        $display("[TB] burst order");
        peak = 0;
        for (int i = 1; i <= 5; i++) drive(1'b1, 8'(i));
        drive(1'b0, 8'h00);
        wait_drain("burst");
        check("burst_peak_4_or_5", int'(peak == 4 || peak == 5), 1);
        check("burst_last", last_tx, 8'h05);

        // Line held busy: 16 fill the FIFO, the 17th is dropped.
        $display("[TB] full and overflow");
        @(negedge clock);
        hold_active = 1'b1;
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(8'h40 + i));
        drive(1'b1, 8'hEE);
        @(posedge clock); #3;
        check("ovf_pulse", o_overflow, 1);
        check("ovf_full", o_full, 1);
        check("ovf_count", o_count, 16);
        drive(1'b0, 8'h00);
        @(posedge clock); #3;
        check("ovf_pulse_ends", o_overflow, 0);

        // Release the line and write in the same cycle as the pop.
        $display("[TB] write while full with pop");
        @(negedge clock);
        hold_active = 1'b0;
        wr_dv       = 1'b1;
        wr_byte     = 8'hAA;
        @(posedge clock); #3;
        check("wfp_overflow", o_overflow, 0);
        check("wfp_count", o_count, 16);
        check("wfp_dv", o_tx_dv, 1);
        drive(1'b0, 8'h00);
        wait_drain("wfp");
        check("wfp_aa_last", last_tx, 8'hAA);

        // Reset during the second of three frames.
        $display("[TB] reset mid-frame");
        base = dv_count;
        drive(1'b1, 8'hA1);
        drive(1'b1, 8'hA2);
        drive(1'b1, 8'hA3);
        drive(1'b0, 8'h00);
        n = 0;
        while (!(dv_count >= base + 2 && stub_busy) && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("mid_second_frame_seen", int'(n < 500), 1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("mid_rst_count", o_count, 0);
        check("mid_rst_dv", o_tx_dv, 0);
        check("mid_rst_empty", o_empty, 1);
        check("mid_rst_byte", o_tx_byte, 0);
        @(negedge clock);
        @(negedge clock);
        reset   = 1'b0;
        wr_dv   = 1'b1;
        wr_byte = 8'h5A;
        drive(1'b0, 8'h00);
        n = 0;
        while (tx_active && n < 100) begin
            @(posedge clock); #3;
            check("mid_no_dv_while_active", o_tx_dv, 0);
            n++;
        end
        wait_drain("mid");
        check("mid_5a_sent", last_tx, 8'h5A);

        // Stream 40 bytes while keeping the FIFO partly filled.
        $display("[TB] pointer wrap");
        spurious_en = 1;
        base = dv_count;
        for (int b = 0; b < 40; ) begin
            if (m_q.size() < 6 && $urandom_range(0, 1) == 1) begin
                drive(1'b1, 8'(b));
                b++;
            end else begin
                drive(1'b0, 8'h00);
            end
        end
        drive(1'b0, 8'h00);
        wait_drain("wrap");
        check("wrap_count_sent", dv_count - base, 40);
        check("wrap_last", last_tx, 8'h27);

        // Random traffic, including drops when the FIFO saturates.
        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom));
        end
        drive(1'b0, 8'h00);
        wait_drain("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
